gemm_tiled_engine: RTL
======================

// Module: gemm_tiled_engine
// PURPOSE
//  Parametrised tiled GeMM engine: C = A x B. A is M_i x K_i, B is K_i x N_i, signed operands.
//  Arbitrary runtime sizes (not only tile multiples); ragged tiles are zero-masked.
//  Sits between packed SRAM A/B (1-cycle read) and SRAM C (1 word = full MxN tile).
//  Streams one (m,n,k) tile step per cycle with no bubbles.
// PARAMETERS
//  InDataWidth   8   operand element width, signed
//  OutDataWidth  32  accumulator/result element width, signed, wraps mod 2^OutDataWidth
//  AddrWidth     16  SRAM address width, all three memories
//  SizeAddrWidth 8   width of runtime size inputs
//  M             4   tile rows (A/C)
//  K             8   tile depth
//  N             4   tile cols (B/C)
// PORTS
//  clk_i           in   1                      clock
//  rst_i           in   1                      reset, asynchronous, active-high
//  start_i         in   1                      start request, sampled in IDLE only
//  M_size_i        in   SizeAddrWidth          M_i, latched at accepted start
//  K_size_i        in   SizeAddrWidth          K_i, latched at accepted start
//  N_size_i        in   SizeAddrWidth          N_i, latched at accepted start
//  sram_a_addr_o   out  AddrWidth              A word address
//  sram_b_addr_o   out  AddrWidth              B word address
//  sram_c_addr_o   out  AddrWidth              C word address
//  sram_a_rdata_i  in   InDataWidth*M*K        A tile, valid 1 cycle after address
//  sram_b_rdata_i  in   InDataWidth*K*N        B tile, valid 1 cycle after address
//  sram_c_wdata_o  out  OutDataWidth*M*N       C tile write data
//  sram_c_we_o     out  1                      C write enable, 1-cycle pulse per tile
//  busy_o          out  1                      high from accepted start until done pulse
//  done_o          out  1                      1-cycle completion pulse
//  err_o           out  1                      1-cycle pulse, with done_o, on zero size
// BEHAVIOUR
//  Reset: all outputs 0, FSM IDLE, counters and accumulators 0. Applies immediately (async).
//  Reset mid-run aborts the run: no further we, no done.
//  Tile counts: MT=ceil(M_i/M), KT=ceil(K_i/K), NT=ceil(N_i/N), S=MT*NT*KT.
//  Layout:
//   A word at mt*KT+kt; element (i,k) at bits [(i*K+k)*InDataWidth +: InDataWidth].
//   B word at kt*NT+nt; element (k,j) at bits [(k*N+j)*InDataWidth +: InDataWidth].
//   C word at mt*NT+nt; element (i,j) at bits [(i*N+j)*OutDataWidth +: OutDataWidth].
//   Addresses wrap mod 2^AddrWidth.
//  Loop order: mt outer, nt middle, kt inner. Addresses are combinational from step counters.
//  FSM IDLE -> RUN -> DRAIN -> IDLE:
//   IDLE: start_i=1 with all sizes nonzero -> latch sizes, busy_o=1, enter RUN.
//     Any size 0 -> stay IDLE; err_o=1 and done_o=1 next cycle; no write.
//   RUN: counts r=0..S-1, one step issued per cycle. After step S-1 -> DRAIN.
//   DRAIN: 2 cycles (last data, last write). Then done_o=1 for 1 cycle, busy_o=0, -> IDLE.
//  start_i while busy_o=1: ignored. Size input changes during a run: ignored.
//  Data pipeline, for step r issued in cycle r:
//   Cycle r+1: acc[i][j] = (kt==0 ? 0 : acc[i][j]) + sum_k a[i][k]*b[k][j].
//   Products are signed InDataWidth x InDataWidth, sign-extended to OutDataWidth; sums wrap.
//  Masking: elements with global k>=K_i contribute 0, whatever the SRAM content.
//   Rows with global m>=M_i and cols with global n>=N_i are written as 0.
//  Write: if step r has kt==KT-1, cycle r+2 drives sram_c_we_o=1, with the registered
//   addr and wdata of that tile.
//   The next tile's kt==0 accumulate in cycle r+2 must not corrupt the written data.
//  Timing: accepted start at edge e0; RUN cycles are 1..S; last we in cycle S+2; done_o in S+3.
//  sram_c_addr_o and sram_c_wdata_o hold their last value when we=0.
// TESTING
//  1 M_i=4,K_i=8,N_i=4; A all 1, B all 2
//    -> one we at addr 0, all 16 C elements 16; done_o 4 cycles after start.
//  2 M_i=4,K_i=24,N_i=4; A=B all 1
//    -> A addrs 0,1,2 on consecutive cycles; single write, all 24; done at cycle 6.
//  3 M_i=5,K_i=3,N_i=6; all SRAM bytes 0x7F incl padding
//    -> 4 writes at addr 0,1,2,3 in order; valid elements 48387, padded rows/cols 0.
//  4 K_i=8, tile 1x1 sizes 4/8/4: A=-128,B=-128 -> 131072; A=-128,B=127 -> -130048.
//  5 start with K_i=0 -> err_o=done_o=1 next cycle, busy_o stays 0, no we.
//    Random sizes 1..64 vs golden model -> bit-exact C.
//  6 rst_i pulsed mid-run of test 3 -> outputs 0 at once; rerun gives identical result.
//    start_i pulse while busy -> ignored.

Source files
------------

// File: rtl/gemm_tiled_engine.sv
// Tiled signed GeMM engine: walks (mt, nt, kt) tile steps over packed A/B SRAMs,
// accumulates one MxN tile at a time and writes it to C as a single word.
module gemm_tiled_engine #(
  parameter int InDataWidth   = 8,
  parameter int OutDataWidth  = 32,
  parameter int AddrWidth     = 16,
  parameter int SizeAddrWidth = 8,
  parameter int M             = 4,
  parameter int K             = 8,
  parameter int N             = 4
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             start_i,
  input  logic [SizeAddrWidth-1:0]         M_size_i,
  input  logic [SizeAddrWidth-1:0]         K_size_i,
  input  logic [SizeAddrWidth-1:0]         N_size_i,
  output logic [AddrWidth-1:0]             sram_a_addr_o,
  output logic [AddrWidth-1:0]             sram_b_addr_o,
  output logic [AddrWidth-1:0]             sram_c_addr_o,
  input  logic [InDataWidth*M*K-1:0]       sram_a_rdata_i,
  input  logic [InDataWidth*K*N-1:0]       sram_b_rdata_i,
  output logic [OutDataWidth*M*N-1:0]      sram_c_wdata_o,
  output logic                             sram_c_we_o,
  output logic                             busy_o,
  output logic                             done_o,
  output logic                             err_o
);
  // state | meaning
  // IDLE  | waiting for start, sizes may be sampled
  // RUN   | one (mt,nt,kt) step issued per cycle
  // DRAIN | last read data and last write in flight
  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_RUN   = 2'd1;
  localparam logic [1:0] S_DRAIN = 2'd2;

  localparam int SW = SizeAddrWidth;
  localparam int PW = 2 * InDataWidth;

  logic [1:0]    state;
  logic          drain_cnt;
  logic [SW-1:0] m_size_q, k_size_q, n_size_q;
  logic [SW-1:0] mt_num, kt_num, nt_num;
  logic [SW-1:0] mt_cnt, kt_cnt, nt_cnt;
  logic          last_k, last_step;

  logic          v_p, last_k_p;
  logic [SW-1:0] mt_p, kt_p, nt_p;

  logic [K-1:0]  k_ok;
  logic [M-1:0]  row_ok;
  logic [N-1:0]  col_ok;
  logic signed [OutDataWidth-1:0] tile_sum [M][N];
  logic signed [OutDataWidth-1:0] acc      [M][N];
  logic signed [OutDataWidth-1:0] acc_next [M][N];

  assign mt_num = SW'((32'(m_size_q) + 32'(M) - 32'd1) / 32'(M));
  assign kt_num = SW'((32'(k_size_q) + 32'(K) - 32'd1) / 32'(K));
  assign nt_num = SW'((32'(n_size_q) + 32'(N) - 32'd1) / 32'(N));

  assign last_k    = (kt_cnt == kt_num - SW'(1));
  assign last_step = last_k && (nt_cnt == nt_num - SW'(1)) && (mt_cnt == mt_num - SW'(1));

  assign sram_a_addr_o = AddrWidth'(32'(mt_cnt) * 32'(kt_num) + 32'(kt_cnt));
  assign sram_b_addr_o = AddrWidth'(32'(kt_cnt) * 32'(nt_num) + 32'(nt_cnt));

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state     <= S_IDLE;
      drain_cnt <= 1'b0;
      m_size_q  <= '0;
      k_size_q  <= '0;
      n_size_q  <= '0;
      mt_cnt    <= '0;
      kt_cnt    <= '0;
      nt_cnt    <= '0;
      busy_o    <= 1'b0;
      done_o    <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      done_o <= 1'b0;
      err_o  <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start_i) begin
            if (M_size_i == '0 || K_size_i == '0 || N_size_i == '0) begin
              err_o  <= 1'b1;
              done_o <= 1'b1;
            end else begin
              m_size_q <= M_size_i;
              k_size_q <= K_size_i;
              n_size_q <= N_size_i;
              mt_cnt   <= '0;
              kt_cnt   <= '0;
              nt_cnt   <= '0;
              busy_o   <= 1'b1;
              state    <= S_RUN;
            end
          end
        end
        S_RUN: begin
          if (last_step) begin
            state     <= S_DRAIN;
            drain_cnt <= 1'b0;
          end else if (!last_k) begin
            kt_cnt <= kt_cnt + SW'(1);
          end else begin
            kt_cnt <= '0;
            if (nt_cnt == nt_num - SW'(1)) begin
              nt_cnt <= '0;
              mt_cnt <= mt_cnt + SW'(1);
            end else begin
              nt_cnt <= nt_cnt + SW'(1);
            end
          end
        end
        S_DRAIN: begin
          if (drain_cnt) begin
            state  <= S_IDLE;
            busy_o <= 1'b0;
            done_o <= 1'b1;
          end else begin
            drain_cnt <= 1'b1;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Global-index masks for the step whose SRAM data is arriving this cycle
  always_comb begin
    for (int k = 0; k < K; k++)
      k_ok[k] = (32'(kt_p) * 32'(K) + 32'(k)) < 32'(k_size_q);
    for (int i = 0; i < M; i++)
      row_ok[i] = (32'(mt_p) * 32'(M) + 32'(i)) < 32'(m_size_q);
    for (int j = 0; j < N; j++)
      col_ok[j] = (32'(nt_p) * 32'(N) + 32'(j)) < 32'(n_size_q);
  end

  always_comb begin : mac
    logic signed [InDataWidth-1:0] a_el, b_el;
    logic signed [PW-1:0]          a_ext, b_ext, prod;
    a_el = '0; b_el = '0; a_ext = '0; b_ext = '0; prod = '0;
    for (int i = 0; i < M; i++) begin
      for (int j = 0; j < N; j++) begin
        tile_sum[i][j] = '0;
        for (int k = 0; k < K; k++) begin
          a_el  = sram_a_rdata_i[(i*K+k)*InDataWidth +: InDataWidth];
          b_el  = sram_b_rdata_i[(k*N+j)*InDataWidth +: InDataWidth];
          a_ext = {{(PW-InDataWidth){a_el[InDataWidth-1]}}, a_el};
          b_ext = {{(PW-InDataWidth){b_el[InDataWidth-1]}}, b_el};
          prod  = a_ext * b_ext;
          if (k_ok[k])
            tile_sum[i][j] = tile_sum[i][j] + {{(OutDataWidth-PW){prod[PW-1]}}, prod};
        end
        acc_next[i][j] = ((kt_p == '0) ? '0 : acc[i][j]) + tile_sum[i][j];
      end
    end
  end

  // Write data is captured in its own register so the next tile's kt==0 step can reuse acc
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      v_p            <= 1'b0;
      last_k_p       <= 1'b0;
      mt_p           <= '0;
      kt_p           <= '0;
      nt_p           <= '0;
      sram_c_we_o    <= 1'b0;
      sram_c_addr_o  <= '0;
      sram_c_wdata_o <= '0;
      for (int i = 0; i < M; i++)
        for (int j = 0; j < N; j++)
          acc[i][j] <= '0;
    end else begin
      v_p         <= (state == S_RUN);
      last_k_p    <= last_k;
      mt_p        <= mt_cnt;
      kt_p        <= kt_cnt;
      nt_p        <= nt_cnt;
      sram_c_we_o <= 1'b0;
      if (v_p) begin
        for (int i = 0; i < M; i++)
          for (int j = 0; j < N; j++)
            acc[i][j] <= acc_next[i][j];
        if (last_k_p) begin
          sram_c_we_o   <= 1'b1;
          sram_c_addr_o <= AddrWidth'(32'(mt_p) * 32'(nt_num) + 32'(nt_p));
          for (int i = 0; i < M; i++)
            for (int j = 0; j < N; j++)
              sram_c_wdata_o[(i*N+j)*OutDataWidth +: OutDataWidth] <=
                (row_ok[i] && col_ok[j]) ? acc_next[i][j] : '0;
        end
      end
    end
  end

endmodule
